// File: rtl/iob_modcnt_chain.sv
// Cascaded mixed-radix modulo counter chain: per-stage modulus, up/down count,
// synchronous parallel load and one-cycle wrap pulses per stage.
module iob_modcnt_chain #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned N_STAGES = 3,
   parameter int unsigned RST_VAL  = 0
) (
   input  logic                         clk_i,
   input  logic                         arst_i,
   input  logic                         rst_i,
   input  logic                         en_i,
   input  logic                         dir_i,
   input  logic                         ld_i,
   input  logic [N_STAGES*DATA_W-1:0]   ld_val_i,
   input  logic [N_STAGES*DATA_W-1:0]   mod_i,
   output logic [N_STAGES*DATA_W-1:0]   data_o,
   output logic [N_STAGES-1:0]          wrap_o,
   output logic                         carry_o
);

   localparam logic [DATA_W-1:0] RST_C  = DATA_W'(RST_VAL);
   localparam logic [DATA_W-1:0] ONE_C  = DATA_W'(1);
   localparam logic [DATA_W-1:0] ZERO_C = DATA_W'(0);

   logic [N_STAGES*DATA_W-1:0] data_r;
   logic [N_STAGES*DATA_W-1:0] nxt_s;
   logic [N_STAGES-1:0]        wrap_r;
   logic [N_STAGES-1:0]        wrap_nxt_s;

   // Next value of every stage; the advance ripples through the whole chain in one cycle
   always_comb begin
      logic              run_s;
      logic              term_s;
      logic [DATA_W-1:0] val_s;
      logic [DATA_W-1:0] lim_s;
      logic [DATA_W-1:0] nv_s;
      run_s      = en_i;
      term_s     = 1'b0;
      val_s      = ZERO_C;
      lim_s      = ZERO_C;
      nv_s       = ZERO_C;
      nxt_s      = '0;
      wrap_nxt_s = '0;
      for (int k = 0; k < N_STAGES; k++) begin
         val_s = data_r[k*DATA_W +: DATA_W];
         // modulus 0 wraps to all ones, i.e. full 2^DATA_W range
         lim_s = mod_i[k*DATA_W +: DATA_W] - ONE_C;
         if (dir_i) begin
            term_s = (val_s == ZERO_C);
            if (val_s == ZERO_C) begin
               nv_s = lim_s;
            end else if (val_s > lim_s) begin
               nv_s = lim_s;
            end else begin
               nv_s = val_s - ONE_C;
            end
         end else begin
            term_s = (val_s >= lim_s);
            if (val_s >= lim_s) begin
               nv_s = ZERO_C;
            end else begin
               nv_s = val_s + ONE_C;
            end
         end
         if (run_s) begin
            nxt_s[k*DATA_W +: DATA_W] = nv_s;
         end else begin
            nxt_s[k*DATA_W +: DATA_W] = val_s;
         end
         wrap_nxt_s[k] = run_s & term_s;
         run_s         = run_s & term_s;
      end
      carry_o = run_s;
   end

   // Stage registers and wrap pulses: async reset, then sync reset, load, advance
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         data_r <= {N_STAGES{RST_C}};
         wrap_r <= '0;
      end else if (rst_i) begin
         data_r <= {N_STAGES{RST_C}};
         wrap_r <= '0;
      end else if (ld_i) begin
         data_r <= ld_val_i;
         wrap_r <= '0;
      end else begin
         data_r <= nxt_s;
         wrap_r <= wrap_nxt_s;
      end
   end

   assign data_o = data_r;
   assign wrap_o = wrap_r;

endmodule

// File: doc/iob_modcnt_chain.md
# iob_modcnt_chain

Parametrised chain of N_STAGES cascaded modulo counters sharing one clock, with a per-stage modulus, up/down direction, synchronous parallel load and per-stage wrap pulses. Stage 0 advances on `en_i`; each higher stage advances when every lower stage wraps in the same cycle, as in a mixed-radix digit counter. Intended for timestamp/time-of-day generators, multi-dimensional address sequencers and prescaler chains, replacing hand-wired stacks of single modulo counters.

## Interface

- `DATA_W`, 8: width of each stage counter and of its modulus.
- `N_STAGES`, 3: number of cascaded stages (≥1).
- `RST_VAL`, 0: reset value of every stage (same value for all stages).

- `clk_i`  in  1  clock, rising edge.
- `arst_i`  in  1  asynchronous reset, active-high.
- `rst_i`  in  1  synchronous reset, active-high.
- `en_i`  in  1  count enable for stage 0.
- `dir_i`  in  1  0 = count up, 1 = count down (all stages).
- `ld_i`  in  1  synchronous load of all stages from `ld_val_i`.
- `ld_val_i`  in  N_STAGES*DATA_W  load values; stage k at bits [k*DATA_W +: DATA_W].
- `mod_i`  in  N_STAGES*DATA_W  moduli; stage k at bits [k*DATA_W +: DATA_W].
- `data_o`  out  N_STAGES*DATA_W  registered stage values, same packing.
- `wrap_o`  out  N_STAGES  registered one-cycle pulse per stage, set in the cycle its value shows the wrapped result.
- `carry_o`  out  1  combinational: asserted when an advance this cycle wraps the top stage (for chaining).

## Operation

- Effective modulus M_k = `mod_i` stage k; value 0 means 2^DATA_W (full range). M_k = 1 pins the stage at 0 and makes it always terminal.
- Terminal condition T_k: up: value ≥ M_k−1; down: value == 0.
- Advance A_0 = `en_i`; A_k = A_{k−1} & T_{k−1}. `carry_o` = A_{N−1} & T_{N−1}.
- On advance, stage k next value:
  - up: value ≥ M_k−1 → 0 (wrap); else value+1.
  - down: value == 0 → M_k−1 (wrap); value > M_k−1 → M_k−1 (no wrap); else value−1.
- `wrap_o[k]` next = A_k & T_k (wrap occurred); 0 otherwise.
- Priority per edge: `arst_i` > `rst_i` > `ld_i` > advance.
  - `arst_i`/`rst_i`: every stage ← RST_VAL, `wrap_o` ← 0.
  - `ld_i`: stage k ← `ld_val_i` stage k unmodified (out-of-range values allowed), `wrap_o` ← 0; `en_i` ignored that cycle.
- `dir_i` and `mod_i` changes take effect the cycle they are presented; no internal state besides stage values and `wrap_o`.
- Arithmetic modulo 2^DATA_W; M_k−1 computed at DATA_W bits (0−1 = all ones = full-range terminal).

## Timing

- Reset values: `data_o` = RST_VAL per stage, `wrap_o` = 0; `carry_o` follows combinationally from the reset state and inputs.
- Latency: `en_i` sampled at edge n → `data_o` and `wrap_o` reflect it after edge n (one cycle). Full cascade resolves in the same edge; no ripple delay between stages.
- `carry_o` is combinational from `en_i`, `dir_i`, `mod_i`, `data_o`; valid before the edge on which the top stage wraps.
- `arst_i` asserted mid-count clears immediately, independent of `clk_i`; deassertion is synchronised externally.
- `rst_i`/`ld_i` held for multiple cycles hold their value; counting resumes on the first edge with both low.

## Test plan

- Up cascade, DATA_W=8, mods {10,6,4}, RST_VAL=0, `en_i` high for 240 cycles → data wraps through all states once, back to {0,0,0}; `wrap_o[0]` pulses every 10 cycles, `wrap_o[1]` every 60, `wrap_o[2]` once at cycle 240; `carry_o` high only in cycle 239.
- Down from {0,0,0}, same mods, one enable → data {9,5,3}, `wrap_o`=3'b111, `carry_o` high in that cycle; next enable → {8,5,3}, `wrap_o`=0.
- Load {9,5,2} with `en_i` high → {9,5,2}, no advance, `wrap_o`=0; next enable → {0,0,3}, `wrap_o`=3'b011.
- Out-of-range: load stage 0 = 200 with mod 10; up enable → 0 with `wrap_o[0]`=1, stage 1 advances; reload 200, down enable → 9, `wrap_o[0]`=0, stage 1 unchanged.
- Edge moduli: mod 0 stage counts 255→0 with wrap; mod 1 stage stays 0 and passes carry every enable.
- Resets: `arst_i` pulse between edges mid-count → outputs RST_VAL immediately; `rst_i` and `ld_i` together → RST_VAL wins.
